// File: rtl/symbol_sequencer_if.sv
// Bit-stream handshake between the framer/FIFO (master) and the symbol sequencer (slave).
interface symbol_sequencer_if;
  logic bit_valid;
  logic bit_data;
  logic bit_last;
  logic bit_ready;

  modport master (output bit_valid, output bit_data, output bit_last, input bit_ready);
  modport slave  (input bit_valid, input bit_data, input bit_last, output bit_ready);
endinterface

// File: rtl/symbol_sequencer.sv
// Turns a valid/ready bit stream into SIZE-sample ROM read bursts, with an idle gap per frame
// and a sticky underrun flag. Define PREAMBLE_EN to prefix each frame with PRE_LEN 1,0,1,0 symbols.
module symbol_sequencer #(
  parameter int SIZE    = 13,
  parameter int m       = $clog2(SIZE),
  parameter int GAP_LEN = 4,
  parameter int PRE_LEN = 4
) (
  input  logic              C,
  input  logic              Reset,
  symbol_sequencer_if.slave bits,
  output logic              sample_en,
  output logic [m-1:0]      sample_idx,
  output logic              sample_pol,
  output logic              sym_start,
  output logic              frame_done,
  output logic              underrun,
  output logic              busy
);

  if (SIZE < 2 || GAP_LEN < 1 || PRE_LEN < 1) begin : g_bad_params
    $error("symbol_sequencer: needs SIZE >= 2, GAP_LEN >= 1, PRE_LEN >= 1");
  end

  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
  localparam logic [m-1:0]  LAST_IDX = m'(SIZE - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_LEN - 1);
`ifdef PREAMBLE_EN
  localparam int PW = (PRE_LEN > 1) ? $clog2(PRE_LEN) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRE_LEN - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    SYMBOL,
    STALL,
`ifdef PREAMBLE_EN
    PREAMBLE,
`endif
    GAP
  } state_t;

  state_t          state_reg, state_next;
  logic [m-1:0]    idx_reg, idx_next;
  logic            pol_reg, pol_next;
  logic            en_reg, en_next;
  logic            start_reg, start_next;
  logic            done_reg, done_next;
  logic            underrun_reg, underrun_next;
  logic            busy_reg;
  logic            last_reg, last_next;
  logic [GW-1:0]   gap_reg, gap_next;
`ifdef PREAMBLE_EN
  logic [PW-1:0]   pre_reg, pre_next;
`endif
  logic            ready;
  logic            xfer;

  // Ready depends only on state and counters so the source never sees a valid->ready loop.
  always_comb begin
    ready = 1'b0;
    case (state_reg)
`ifdef PREAMBLE_EN
      IDLE:     ready = 1'b0;
      PREAMBLE: ready = (idx_reg == LAST_IDX) && (pre_reg == PRE_LAST);
`else
      IDLE:     ready = 1'b1;
`endif
      SYMBOL:   ready = (idx_reg == LAST_IDX) && !last_reg;
      STALL:    ready = 1'b1;
      default:  ready = 1'b0;
    endcase
  end

  assign bits.bit_ready = ready;
  assign xfer           = bits.bit_valid & ready;

  always_comb begin
    state_next    = state_reg;
    idx_next      = idx_reg;
    pol_next      = pol_reg;
    en_next       = 1'b0;
    start_next    = 1'b0;
    done_next     = 1'b0;
    underrun_next = underrun_reg;
    last_next     = last_reg;
    gap_next      = gap_reg;
`ifdef PREAMBLE_EN
    pre_next      = pre_reg;
`endif

    case (state_reg)
      IDLE: begin
        idx_next = '0;
`ifdef PREAMBLE_EN
        // The source's bit stays pending until the last preamble sample.
        if (bits.bit_valid) begin
          state_next = PREAMBLE;
          pol_next   = 1'b1;
          en_next    = 1'b1;
          start_next = 1'b1;
          pre_next   = '0;
        end
`endif
      end
      SYMBOL: begin
        if (idx_reg == LAST_IDX) begin
          if (last_reg) begin
            state_next = GAP;
            idx_next   = '0;
            gap_next   = '0;
            done_next  = 1'b1;
          end else if (!xfer) begin
            state_next    = STALL;
            idx_next      = '0;
            underrun_next = 1'b1;
          end
        end else begin
          idx_next = (idx_reg > LAST_IDX) ? '0 : idx_reg + 1'b1;
          en_next  = 1'b1;
        end
      end
`ifdef PREAMBLE_EN
      PREAMBLE: begin
        if (idx_reg == LAST_IDX) begin
          if (pre_reg != PRE_LAST) begin
            idx_next   = '0;
            pol_next   = ~pol_reg;
            en_next    = 1'b1;
            start_next = 1'b1;
            pre_next   = pre_reg + 1'b1;
          end else if (!xfer) begin
            state_next = STALL;
            idx_next   = '0;
          end
        end else begin
          idx_next = (idx_reg > LAST_IDX) ? '0 : idx_reg + 1'b1;
          en_next  = 1'b1;
        end
      end
`endif
      STALL: idx_next = '0;
      GAP: begin
        idx_next = '0;
        if (gap_reg == GAP_LAST) state_next = IDLE;
        else                     gap_next   = gap_reg + 1'b1;
      end
      default: begin
        state_next = IDLE;
        idx_next   = '0;
      end
    endcase

    // Every accepted bit starts a fresh symbol the next cycle, whichever state accepted it.
    if (xfer) begin
      state_next = SYMBOL;
      idx_next   = '0;
      pol_next   = bits.bit_data;
      en_next    = 1'b1;
      start_next = 1'b1;
      last_next  = bits.bit_last;
    end
  end

  always_ff @(posedge C) begin
    if (Reset) begin
      state_reg    <= IDLE;
      idx_reg      <= '0;
      pol_reg      <= 1'b0;
      en_reg       <= 1'b0;
      start_reg    <= 1'b0;
      done_reg     <= 1'b0;
      underrun_reg <= 1'b0;
      busy_reg     <= 1'b0;
      last_reg     <= 1'b0;
      gap_reg      <= '0;
`ifdef PREAMBLE_EN
      pre_reg      <= '0;
`endif
    end else begin
      state_reg    <= state_next;
      idx_reg      <= idx_next;
      pol_reg      <= pol_next;
      en_reg       <= en_next;
      start_reg    <= start_next;
      done_reg     <= done_next;
      underrun_reg <= underrun_next;
      busy_reg     <= (state_next != IDLE);
      last_reg     <= last_next;
      gap_reg      <= gap_next;
`ifdef PREAMBLE_EN
      pre_reg      <= pre_next;
`endif
    end
  end

  assign sample_en  = en_reg;
  assign sample_idx = idx_reg;
  assign sample_pol = pol_reg;
  assign sym_start  = start_reg;
  assign frame_done = done_reg;
  assign underrun   = underrun_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_symbol_sequencer.sv
// Scoreboard bench for symbol_sequencer: the driver predicts every sample and frame_done
// cycle from accepted bits; a negedge monitor pops and compares what the DUT presents.
module tb_symbol_sequencer;
  localparam int SIZE    = 13;
  localparam int GAP_LEN = 4;
  localparam int PRE_LEN = 4;
  localparam int M       = $clog2(SIZE);
  localparam int BOUND   = 500;

  logic         C = 1'b0;
  logic         Reset;
  logic         sample_en;
  logic [M-1:0] sample_idx;
  logic         sample_pol;
  logic         sym_start;
  logic         frame_done;
  logic         underrun;
  logic         busy;

  symbol_sequencer_if bus ();

  symbol_sequencer #(.SIZE(SIZE), .GAP_LEN(GAP_LEN), .PRE_LEN(PRE_LEN)) dut (
    .C          (C),
    .Reset      (Reset),
    .bits       (bus.slave),
    .sample_en  (sample_en),
    .sample_idx (sample_idx),
    .sample_pol (sample_pol),
    .sym_start  (sym_start),
    .frame_done (frame_done),
    .underrun   (underrun),
    .busy       (busy)
  );

  always #5 C = ~C;

  int cyc = 0;
  always @(posedge C) cyc <= cyc + 1;

  typedef struct {
    int at;
    int idx;
    bit pol;
    bit start;
  } samp_t;

  samp_t exp_q[$];
  int    done_q[$];
  int    errors = 0;
  int    checks = 0;
  bit    mon_en = 1'b0;

  // Reference model state: timing of the previous accepted bit and the expected sticky flag.
  int    prev_t = 0;
  bit    prev_open = 1'b0;
  bit    underrun_exp = 1'b0;
  int    last_t = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_symbol(input int t0, input bit pol);
    for (int i = 0; i < SIZE; i++) begin
      samp_t s;
      s.at = t0 + i; s.idx = i; s.pol = pol; s.start = (i == 0);
      exp_q.push_back(s);
    end
  endtask

  always @(negedge C) begin
    if (mon_en) begin
      if (sample_en) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_sample_en", int'(sample_en), 0);
        end else begin
          samp_t e;
          e = exp_q.pop_front();
          chk("sample_cycle", cyc, e.at);
          chk("sample_idx", int'(sample_idx), e.idx);
          chk("sample_pol", int'(sample_pol), int'(e.pol));
          chk("sym_start", int'(sym_start), int'(e.start));
          chk("busy_during_sample", int'(busy), 1);
        end
      end else begin
        if (sym_start) chk("sym_start_without_sample", int'(sym_start), 0);
        if (exp_q.size() > 0 && exp_q[0].at <= cyc) begin
          chk("sample_en_missing", int'(sample_en), 1);
          void'(exp_q.pop_front());
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) chk("unexpected_frame_done", int'(frame_done), 0);
        else                    chk("frame_done_cycle", cyc, done_q.pop_front());
      end else if (done_q.size() > 0 && done_q[0] < cyc) begin
        chk("frame_done_missing", int'(frame_done), 1);
        void'(done_q.pop_front());
      end
    end
  end

  // Present one bit after `delay` idle cycles; returns at the negedge after it was accepted.
  task automatic send_bit(input bit d, input bit l, input int delay, input bit first);
    int guard;
    bit r;
    int t;
    bit pre_pushed;
    guard = 0;
    pre_pushed = 1'b0;
    bus.bit_valid = 1'b0;
    repeat (delay) @(negedge C);
    bus.bit_data  = d;
    bus.bit_last  = l;
    bus.bit_valid = 1'b1;
    while (1) begin
      #1;
      r = bus.bit_ready;
      t = cyc + 1;
`ifdef PREAMBLE_EN
      if (first && !pre_pushed && !busy) begin
        for (int k = 0; k < PRE_LEN; k++) push_symbol(t + k * SIZE, (k % 2) == 0);
        pre_pushed = 1'b1;
      end
`else
      pre_pushed = first;
`endif
      if (r) begin
        if (prev_open && t != prev_t + SIZE) underrun_exp = 1'b1;
        push_symbol(t, d);
        if (l) done_q.push_back(t + SIZE);
        prev_open = !l;
        prev_t    = t;
        last_t    = t;
      end
      @(posedge C);
      @(negedge C);
      if (r) break;
      guard++;
      if (guard >= BOUND) begin
        chk("bit_ready_timeout", int'(bus.bit_ready), 1);
        break;
      end
    end
    bus.bit_valid = 1'b0;
  endtask

  // After the last bit: busy must drop exactly SIZE + GAP_LEN cycles after the final transfer.
  task automatic finish_frame();
    int g;
    g = 0;
    while (busy && g < BOUND) begin
      @(negedge C);
      g++;
    end
    chk("idle_return_cycle", cyc, last_t + SIZE + GAP_LEN);
`ifdef PREAMBLE_EN
    chk("bit_ready_in_idle", int'(bus.bit_ready), 0);
`else
    chk("bit_ready_in_idle", int'(bus.bit_ready), 1);
`endif
    chk("underrun_flag", int'(underrun), int'(underrun_exp));
  endtask

  task automatic send_frame(input int n, input logic [7:0] data, input int d_first, input int d_mid);
    for (int k = 0; k < n; k++)
      send_bit(data[k], k == n - 1, (k == 0) ? d_first : d_mid, k == 0);
    finish_frame();
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_sample_en"}, int'(sample_en), 0);
    chk({tag, "_sample_idx"}, int'(sample_idx), 0);
    chk({tag, "_underrun"}, int'(underrun), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_sym_start"}, int'(sym_start), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    bus.bit_valid = 1'b0;
    bus.bit_data  = 1'b0;
    bus.bit_last  = 1'b0;
    Reset = 1'b1;

    // Reset with a bit on offer: nothing may be accepted.
    @(negedge C);
    bus.bit_valid = 1'b1; bus.bit_data = 1'b1; bus.bit_last = 1'b1;
    repeat (3) @(negedge C);
    check_reset_outputs("reset");
    chk("reset_sample_pol", int'(sample_pol), 0);
    bus.bit_valid = 1'b0;
    Reset = 1'b0;
    mon_en = 1'b1;
    @(negedge C);
    chk("after_reset_busy", int'(busy), 0);

    send_frame(1, 8'b1, 0, 0);        // single-bit frame
    send_frame(3, 8'b101, 0, 0);      // back-to-back 1,0,1
    send_frame(2, 8'b10, 0, SIZE + 4); // 0 then a 5-cycle stall before the last bit

    // Reset in the middle of a symbol (idx 6) drops it and clears underrun.
    send_bit(1'b1, 1'b0, 0, 1'b1);
    g = 0;
    while (sample_idx != M'(6) && g < BOUND) begin
      @(negedge C);
      g++;
    end
    chk("reached_idx6", int'(sample_idx), 6);
    mon_en = 1'b0;
    Reset  = 1'b1;
    @(negedge C);
    check_reset_outputs("midreset");
    exp_q.delete();
    done_q.delete();
    prev_open    = 1'b0;
    underrun_exp = 1'b0;
    Reset  = 1'b0;
    mon_en = 1'b1;

    for (int f = 0; f < 20; f++) begin
      int n;
      int dm;
      n  = $urandom_range(1, 4);
      dm = ($urandom_range(0, 9) < 7) ? 0 : $urandom_range(1, 20);
      send_frame(n, 8'($urandom), $urandom_range(0, 3), dm);
    end

    repeat (3) @(negedge C);
    chk("pending_samples", exp_q.size(), 0);
    chk("pending_frame_done", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/symbol_sequencer.md
Name: symbol_sequencer

Overview:
Control block for the waveform-ROM sample generator. It accepts a stream of data bits over a valid/ready handshake and converts each bit into one symbol of SIZE consecutive ROM sample cycles. For each sample cycle it drives the sample index, the polarity select (1 = positive waveform table, 0 = negative waveform table) and a read enable. It also frames the bursts: it inserts an idle gap after each frame and flags underruns. It sits between the bit source (framer/FIFO) and the sample ROM.

Parameters:
SIZE, 13, samples per symbol; must be >= 2
m, $clog2(SIZE), sample index width
GAP_LEN, 4, idle cycles inserted after the last symbol of a frame; must be >= 1
PRE_LEN, 4, preamble symbols per frame; used only with PREAMBLE_EN

Ports:
C  input  1  clock, all logic on rising edge
Reset  input  1  reset, synchronous, active-high
bit_valid  input  1  source has a bit available
bit_data  input  1  data bit; 1 selects the positive table, 0 the negative table
bit_last  input  1  qualifies bit_data as the final bit of a frame
bit_ready  output  1  sequencer accepts a bit this cycle when bit_valid=1
sample_en  output  1  ROM read enable; sample_idx and sample_pol are valid
sample_idx  output  m  ROM address, 0..SIZE-1
sample_pol  output  1  polarity select to the ROM
sym_start  output  1  one-cycle pulse coinciding with sample_idx=0 of every symbol
frame_done  output  1  one-cycle pulse on the first GAP cycle
underrun  output  1  sticky; set when a mid-frame bit was not available in time
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (synchronous, active-high, overrides everything):
  - state=IDLE.
  - sample_en=0, sample_idx=0, sample_pol=0.
  - sym_start=0, frame_done=0, underrun=0, busy=0.
  - Internal last-flag and gap counter cleared.
  - Reset asserted mid-symbol aborts the symbol immediately; the bit in flight is dropped.
- All outputs are registered.
- States: IDLE, SYMBOL, STALL, GAP.
- A bit transfer is bit_valid & bit_ready on a rising edge. Hold rules:
  - bit_ready is combinational from state and counter only, never from bit_valid.
  - The source must hold bit_data/bit_last stable while bit_valid=1 and bit_ready=0.
- IDLE:
  - Outputs: bit_ready=1, sample_en=0.
  - On transfer: next cycle state=SYMBOL, sample_idx=0, sample_pol=bit_data, sample_en=1, sym_start=1; last-flag := bit_last.
  - Latency from accepting edge to first sample: 1 cycle.
- SYMBOL:
  - sample_en=1; sample_idx increments by 1 per cycle.
  - bit_ready=1 only while sample_idx==SIZE-1 and last-flag=0; the next bit is prefetched on that cycle.
  - At sample_idx==SIZE-1:
    - Transfer occurs: wrap sample_idx to 0, load the new polarity, pulse sym_start, update last-flag. Back-to-back symbols have no bubble.
    - last-flag=1: go to GAP, sample_en=0, frame_done=1.
    - No transfer and last-flag=0: go to STALL, sample_en=0, underrun:=1.
- STALL:
  - bit_ready=1, sample_en=0, sample_idx=0.
  - On transfer: behave as the IDLE transfer (next cycle SYMBOL, idx 0, sym_start=1).
- GAP:
  - bit_ready=0, sample_en=0.
  - Counts GAP_LEN cycles, then returns to IDLE.
  - The first cycle after GAP is IDLE with bit_ready=1.
- sample_pol holds its value when sample_en=0.
- underrun is cleared only by Reset.
- The sample index compare uses the full m bits. Values SIZE..2^m-1 never occur; if reached, the index is forced to 0.

Optional Feature:
PREAMBLE_EN
- Defined:
  - A transfer from IDLE is not consumed immediately. bit_ready=0 after the accepting condition is seen; the source holds its bit.
  - The sequencer first emits PRE_LEN preamble symbols with polarity 1,0,1,0... Each is SIZE samples, with sym_start pulses and sample_en=1.
  - It then accepts the held bit during the last preamble sample (bit_ready=1) and continues as normal.
  - Preamble symbols never set underrun.
  - Adds an internal state PREAMBLE and a log2(PRE_LEN) counter.
- Undefined: no preamble; behaviour exactly as above; PRE_LEN unused.

Test Plan:
- Reset check: hold Reset 3 cycles with bit_valid=1.
  -> bit_ready ignored; all outputs 0; busy=0; no transfer.
- Single-bit frame: bit 1 with bit_last=1 from IDLE.
  -> sample_en=1 for 13 cycles, idx 0..12, pol=1, one sym_start.
  -> frame_done on cycle 14, then 4 GAP cycles, then bit_ready=1.
- Back-to-back 3-bit frame: bits 1,0,1 with the last on bit 3, source always valid.
  -> 39 continuous sample_en cycles; idx wraps 12->0 twice; pol 1,0,1; 3 sym_start pulses; underrun=0.
- Underrun: bit 0 (not last), source withholds for 5 cycles, then sends bit 1 with last.
  -> STALL with sample_en=0 for 5 cycles; underrun=1 and stays set.
  -> Second symbol starts idx 0 one cycle after the transfer.
- Reset mid-symbol: assert Reset at idx=6.
  -> next cycle sample_en=0, idx=0, IDLE, underrun=0.
- PREAMBLE_EN build: single-bit frame, bit 0, last.
  -> 4 preamble symbols with pol 1,0,1,0 (52 cycles), then data symbol with pol 0, then frame_done.
